// File: rtl/byte_encode_stream.sv
// -----------------------------------------------------------------------------
// byte_encode_stream
//   Streaming ByteEncode_ELL. Packs NUM_COEFFS coefficients of ELL bits each,
//   LSB-first, into a NUM_COEFFS*ELL/8 byte stream. Coefficients enter through
//   one valid/ready channel, bytes leave through another. With ELL==12 each
//   coefficient is reduced once modulo Q before packing.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        begin a frame (only looked at while idle)
//   coeff_in     coefficient value, ELL bits
//   coeff_valid  coeff_in is valid
//   coeff_ready  engine takes coeff_in this cycle
//   byte_out     packed byte (low byte of the bit accumulator)
//   byte_valid   byte_out is valid
//   byte_ready   downstream takes byte_out this cycle
//   busy         frame in progress
//   done         one-cycle pulse after the last byte handshake
// -----------------------------------------------------------------------------
module byte_encode_stream #(
    parameter int ELL        = 12,
    parameter int NUM_COEFFS = 256,
    parameter int Q          = 3329,
    parameter int BYTE_COUNT = NUM_COEFFS * ELL / 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [ELL-1:0] coeff_in,
    input  logic           coeff_valid,
    output logic           coeff_ready,
    output logic [7:0]     byte_out,
    output logic           byte_valid,
    input  logic           byte_ready,
    output logic           busy,
    output logic           done
);

    // A push only happens with fewer than 8 bits held, so the accumulator
    // never needs more than ELL+7 bits.
    localparam int ACC_W  = ELL + 7;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int CC_W   = $clog2(NUM_COEFFS + 1);
    localparam int BC_W   = $clog2(BYTE_COUNT + 1);

    localparam logic [FILL_W-1:0] FILL_BYTE = FILL_W'(8);
    localparam logic [FILL_W-1:0] FILL_ELL  = FILL_W'(ELL);
    localparam logic [CC_W-1:0]   CC_MAX    = CC_W'(NUM_COEFFS);
    localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(BYTE_COUNT - 1);
    localparam logic [ELL-1:0]    Q_L       = ELL'(Q);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t            state, state_nx;
    logic [ACC_W-1:0]  acc;
    logic [FILL_W-1:0] fill;
    logic [CC_W-1:0]   coeff_cnt;
    logic [BC_W-1:0]   byte_cnt;

    logic              push, pop, last_pop;
    logic [ELL-1:0]    red;
    logic [ACC_W-1:0]  ins;

    // ------------------------------------------------------------------
    // Handshake qualifiers, all derived from registered state only.
    // ------------------------------------------------------------------
    assign coeff_ready = (state == S_ACCEPT) && (fill < FILL_BYTE) &&
                         (coeff_cnt < CC_MAX);
    assign byte_valid  = ((state == S_ACCEPT) || (state == S_DRAIN)) &&
                         (fill >= FILL_BYTE);
    assign byte_out    = acc[7:0];
    assign busy        = (state == S_ACCEPT) || (state == S_DRAIN);
    assign done        = (state == S_FIN);

    // push needs fill<8 and pop needs fill>=8: they are mutually exclusive.
    assign push     = coeff_valid && coeff_ready;
    assign pop      = byte_valid && byte_ready;
    assign last_pop = pop && (byte_cnt == BC_LAST);

    // Single conditional subtraction: inputs are at most 2^12-1 < 2Q.
    always_comb begin
        red = coeff_in;
        if ((ELL == 12) && (coeff_in >= Q_L))
            red = coeff_in - Q_L;
    end

    // fill<8 when pushing, so the shifted coefficient stays inside ACC_W.
    assign ins = ACC_W'(red) << fill;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nx = S_ACCEPT;
            end
            S_ACCEPT: begin
                // The final byte can leave in the same cycle the coefficient
                // count saturates, so check for it here as well.
                if (last_pop)
                    state_nx = S_FIN;
                else if (coeff_cnt == CC_MAX)
                    state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (last_pop)
                    state_nx = S_FIN;
            end
            S_FIN: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bit accumulator and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            fill      <= '0;
            coeff_cnt <= '0;
            byte_cnt  <= '0;
        end else if ((state == S_IDLE) && start) begin
            acc       <= '0;
            fill      <= '0;
            coeff_cnt <= '0;
            byte_cnt  <= '0;
        end else if (push) begin
            acc       <= acc | ins;
            fill      <= fill + FILL_ELL;
            coeff_cnt <= coeff_cnt + 1'b1;
        end else if (pop) begin
            acc       <= acc >> 8;
            fill      <= fill - FILL_BYTE;
            byte_cnt  <= byte_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_byte_encode_stream.sv
// -----------------------------------------------------------------------------
// tb_byte_encode_stream
//   Directed bench for byte_encode_stream. Four instances (ELL = 12, 4, 1, 10)
//   share one set of stimulus signals; sel picks which instance is driven and
//   observed. Inputs change on the falling edge, outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_byte_encode_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        coeff_valid = 1'b0;
    logic        byte_ready = 1'b0;
    logic [11:0] coeff_in = '0;
    int          sel = 0;

    logic        coeff_ready, byte_valid, busy, done;
    logic [7:0]  byte_out;

    logic [3:0]      st, cv, br;
    logic [3:0]      c_rdy, b_vld, bsy, dn;
    logic [3:0][7:0] b_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] coeffs [256];
    logic [7:0]  rx [$];
    logic [7:0]  exp_b [$];
    int          done_cnt;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            st[k] = start && (sel == k);
            cv[k] = coeff_valid && (sel == k);
            br[k] = byte_ready && (sel == k);
        end
    end

    assign coeff_ready = c_rdy[sel[1:0]];
    assign byte_valid  = b_vld[sel[1:0]];
    assign busy        = bsy[sel[1:0]];
    assign done        = dn[sel[1:0]];
    assign byte_out    = b_out[sel[1:0]];

    byte_encode_stream #(.ELL(12)) u_e12 (
        .clk(clk), .rst(rst), .start(st[0]), .coeff_in(coeff_in[11:0]),
        .coeff_valid(cv[0]), .coeff_ready(c_rdy[0]), .byte_out(b_out[0]),
        .byte_valid(b_vld[0]), .byte_ready(br[0]), .busy(bsy[0]), .done(dn[0]));

    byte_encode_stream #(.ELL(4)) u_e4 (
        .clk(clk), .rst(rst), .start(st[1]), .coeff_in(coeff_in[3:0]),
        .coeff_valid(cv[1]), .coeff_ready(c_rdy[1]), .byte_out(b_out[1]),
        .byte_valid(b_vld[1]), .byte_ready(br[1]), .busy(bsy[1]), .done(dn[1]));

    byte_encode_stream #(.ELL(1)) u_e1 (
        .clk(clk), .rst(rst), .start(st[2]), .coeff_in(coeff_in[0:0]),
        .coeff_valid(cv[2]), .coeff_ready(c_rdy[2]), .byte_out(b_out[2]),
        .byte_valid(b_vld[2]), .byte_ready(br[2]), .busy(bsy[2]), .done(dn[2]));

    byte_encode_stream #(.ELL(10)) u_e10 (
        .clk(clk), .rst(rst), .start(st[3]), .coeff_in(coeff_in[9:0]),
        .coeff_valid(cv[3]), .coeff_ready(c_rdy[3]), .byte_out(b_out[3]),
        .byte_valid(b_vld[3]), .byte_ready(br[3]), .busy(bsy[3]), .done(dn[3]));

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Start a frame and run the handshake loop. Stops on done, after
    // stop_bytes bytes (if nonzero) or stop_feed coefficients (if nonzero).
    // pv/pr are the percentages of cycles with coeff_valid/byte_ready held low.
    task automatic run(input int n_feed, input int stop_bytes, input int stop_feed,
                       input int pv, input int pr, input int max_cyc);
        int          fed = 0;
        int          cyc = 0;
        bit          fin = 1'b0;
        bit          hold = 1'b0;
        logic [7:0]  hold_b = '0;
        rx.delete();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        while (!fin) begin
            coeff_valid = (fed < n_feed) && ($urandom_range(99) >= pv);
            coeff_in    = (fed < 256) ? coeffs[fed] : 12'd0;
            byte_ready  = ($urandom_range(99) >= pr);
            #1;
            if (hold) begin
                chk("stall_valid", {31'd0, byte_valid}, 32'd1);
                chk("stall_data", {24'd0, byte_out}, {24'd0, hold_b});
            end
            hold   = byte_valid && !byte_ready;
            hold_b = byte_out;
            if (coeff_valid && coeff_ready) fed++;
            if (byte_valid && byte_ready) rx.push_back(byte_out);
            if (done) begin
                done_cnt++;
                chk("busy_in_fin", {31'd0, busy}, 32'd0);
                fin = 1'b1;
            end else if (stop_bytes > 0 && rx.size() == stop_bytes) begin
                fin = 1'b1;
            end else if (stop_feed > 0 && fed == stop_feed) begin
                fin = 1'b1;
            end
            cyc++;
            if (!fin && cyc > max_cyc) begin
                chk("timeout", 32'd1, 32'd0);
                fin = 1'b1;
            end
            if (!fin) @(negedge clk);
        end
        // let the handshake set up for this edge complete, then idle inputs
        @(negedge clk);
        coeff_valid = 1'b0;
        byte_ready  = 1'b0;
        #1;
    endtask

    task automatic check_post_frame(input string tag);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cready_low"}, {31'd0, coeff_ready}, 32'd0);
        chk({tag, "_bvalid_low"}, {31'd0, byte_valid}, 32'd0);
    endtask

    // Bit-level reference: bit p of the stream is bit (p % 10) of coeff p/10.
    task automatic model10();
        logic [7:0] b;
        int         p;
        exp_b.delete();
        for (int k = 0; k < 320; k++) begin
            b = '0;
            for (int j = 0; j < 8; j++) begin
                p    = k * 8 + j;
                b[j] = coeffs[p / 10][p % 10];
            end
            exp_b.push_back(b);
        end
    endtask

    task automatic cmp_stream(input string tag);
        int nb = 0;
        chk({tag, "_len"}, rx.size(), exp_b.size());
        for (int k = 0; k < rx.size() && k < exp_b.size(); k++)
            if (rx[k] !== exp_b[k]) nb++;
        chk({tag, "_bytes_bad"}, nb, 0);
    endtask

    initial begin
        int nb;

        // reset state
        sel = 0;
        #1;
        chk("rst_cready", {31'd0, coeff_ready}, 32'd0);
        chk("rst_bvalid", {31'd0, byte_valid}, 32'd0);
        chk("rst_bout", {24'd0, byte_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ELL=12: 0x001, 0x002 -> 01 20 00, then fill back at 0
        coeffs[0] = 12'h001;
        coeffs[1] = 12'h002;
        run(2, 3, 0, 0, 0, 100);
        chk("e12a_len", rx.size(), 3);
        chk("e12a_b0", {24'd0, rx[0]}, 32'h01);
        chk("e12a_b1", {24'd0, rx[1]}, 32'h20);
        chk("e12a_b2", {24'd0, rx[2]}, 32'h00);
        chk("e12a_fill0_bvalid", {31'd0, byte_valid}, 32'd0);
        chk("e12a_fill0_cready", {31'd0, coeff_ready}, 32'd1);
        rst_pulse();

        // ELL=12 reduction: 3329, 4095, 3328 -> 0, 766, 3328
        coeffs[0] = 12'd3329;
        coeffs[1] = 12'd4095;
        coeffs[2] = 12'd3328;
        run(3, 4, 0, 0, 0, 100);
        chk("e12b_len", rx.size(), 4);
        chk("e12b_b0", {24'd0, rx[0]}, 32'h00);
        chk("e12b_b1", {24'd0, rx[1]}, 32'hE0);
        chk("e12b_b2", {24'd0, rx[2]}, 32'h2F);
        chk("e12b_b3", {24'd0, rx[3]}, 32'h00);
        rst_pulse();

        // ELL=4: alternating 3, A over a full frame -> 128 x 0xA3
        sel = 1;
        for (int i = 0; i < 256; i++) coeffs[i] = (i % 2 == 0) ? 12'h3 : 12'hA;
        run(256, 0, 0, 0, 0, 2000);
        chk("e4_len", rx.size(), 128);
        nb = 0;
        foreach (rx[k]) if (rx[k] !== 8'hA3) nb++;
        chk("e4_bytes_bad", nb, 0);
        check_post_frame("e4");

        // ELL=1: only bits 0 and 255 set -> 01, 00 x 30, 80
        sel = 2;
        for (int i = 0; i < 256; i++) coeffs[i] = 12'd0;
        coeffs[0]   = 12'd1;
        coeffs[255] = 12'd1;
        run(256, 0, 0, 0, 0, 2000);
        chk("e1_len", rx.size(), 32);
        chk("e1_b0", {24'd0, rx[0]}, 32'h01);
        chk("e1_b31", {24'd0, rx[31]}, 32'h80);
        nb = 0;
        for (int k = 1; k < 31 && k < rx.size(); k++) if (rx[k] !== 8'h00) nb++;
        chk("e1_mid_bad", nb, 0);
        check_post_frame("e1");

        // ELL=10: random coefficients, ~30% throttling on both sides
        sel = 3;
        for (int i = 0; i < 256; i++) coeffs[i] = 12'($urandom_range(1023));
        model10();
        run(256, 0, 0, 30, 30, 5000);
        cmp_stream("e10");
        check_post_frame("e10");

        // Back-to-back frame: start in the cycle after done
        for (int i = 0; i < 256; i++) coeffs[i] = 12'($urandom_range(1023));
        model10();
        run(256, 0, 0, 0, 0, 2000);
        cmp_stream("e10b");

        // Asynchronous reset mid-frame after 100 coefficients
        for (int i = 0; i < 256; i++) coeffs[i] = 12'($urandom_range(1023));
        run(256, 0, 100, 20, 20, 2000);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cready", {31'd0, coeff_ready}, 32'd0);
        chk("arst_bvalid", {31'd0, byte_valid}, 32'd0);
        chk("arst_bout", {24'd0, byte_out}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        byte_ready = 1'b1;
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (byte_valid || busy) nb++;
        end
        byte_ready = 1'b0;
        chk("arst_quiet", nb, 0);
        for (int i = 0; i < 256; i++) coeffs[i] = 12'($urandom_range(1023));
        model10();
        run(256, 0, 0, 30, 30, 5000);
        cmp_stream("arst_frame");
        check_post_frame("arst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/byte_encode_stream.md
Name: byte_encode_stream

Overview:
- Streaming ByteEncode_ELL: packs NUM_COEFFS coefficients of ELL bits, LSB-first, into a 32*ELL-byte stream.
- Inverse of the decode path that unpacks bytes into coefficients.
- Feeds the encryption/keygen serializers for t-hat/ek (ELL=12), ciphertext u/v (ELL=du/dv) and message (ELL=1).
- Sequential frame engine with valid/ready on both sides.

Parameters:
- ELL, 12, coefficient width in bits (1..12).
- NUM_COEFFS, 256, coefficients per frame.
- Q, 3329, modulus applied when ELL==12.
- BYTE_COUNT, 32*ELL, bytes emitted per frame (NUM_COEFFS*ELL/8).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a frame; sampled in IDLE only.
- coeff_in  input  ELL  coefficient value.
- coeff_valid  input  1  coeff_in valid.
- coeff_ready  output  1  engine accepts coeff_in this cycle.
- byte_out  output  8  packed byte.
- byte_valid  output  1  byte_out valid.
- byte_ready  input  1  downstream accepts byte_out.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse after the last byte handshake.

Behaviour:
- Reset (async, active-high): state=IDLE; accumulator=0; fill=0; coeff_cnt=0; byte_cnt=0. Outputs: coeff_ready=0, byte_valid=0, byte_out=0, busy=0, done=0.
- Reset mid-frame discards all partial data. No bytes are emitted after reset deassertion until a new start.
- States:
  - IDLE: start=1 -> ACCEPT, busy=1, counters cleared.
  - ACCEPT: runs while coeff_cnt<NUM_COEFFS or fill>0 -> DRAIN once coeff_cnt==NUM_COEFFS.
  - DRAIN: emits remaining bytes. When byte_cnt reaches BYTE_COUNT on a handshake -> FIN.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- start outside IDLE is ignored.
- Accumulator: ELL+7 bits wide. fill is the number of valid bits (0..ELL+7). Bits are appended at bit position fill, LSB-first.
- coeff_ready = (state==ACCEPT) && (fill<8) && (coeff_cnt<NUM_COEFFS). Combinational from registers only; never depends on coeff_valid.
- Coefficient accept on coeff_valid && coeff_ready:
  - Reduce: if ELL==12 and coeff_in>=Q, use coeff_in-Q (single subtraction; 4095 -> 766). Otherwise use coeff_in unchanged (already mod 2^ELL).
  - accumulator |= reduced << fill; fill += ELL; coeff_cnt++.
- byte_valid = (fill>=8). byte_out = accumulator[7:0], registered and stable while byte_valid && !byte_ready.
- Byte pop on byte_valid && byte_ready: accumulator >>= 8; fill -= 8; byte_cnt++.
- A push and a pop can never occur in the same cycle, because push requires fill<8 and pop requires fill>=8.
- Latency: first byte_valid one cycle after a coefficient handshake that makes fill>=8.
- Steady throughput with no backpressure: one handshake (coeff or byte) per cycle.
- 256*ELL is a multiple of 8, so fill==0 at frame end. No padding byte is ever produced.
- Backpressure: byte_ready=0 holds byte_out/byte_valid and blocks coefficient intake (fill stays >=8).
- coeff_valid deasserted: the engine waits with no bubble penalty beyond the stall.
- After FIN, coeff_ready=0 and byte_valid=0 until the next start. The next start can be in the cycle after done.

Test Plan:
- ELL=12; start; coeffs 0x001, 0x002 -> bytes 0x01, 0x20, 0x00; fill returns to 0 after the third byte.
- ELL=12; coeffs 3329, 4095, 3328 -> packed values 0, 766, 3328; first 4 bytes 0x00, 0xE0, 0x2F, 0x00.
- ELL=4; full frame of alternating 0x3, 0xA -> 128 bytes all 0xA3; done pulses exactly once after the 128th handshake; busy low the cycle after done.
- ELL=1; 256 coeffs with only index 0 and index 255 set -> 32 bytes: byte0=0x01, byte31=0x80, rest 0x00.
- Random byte_ready/coeff_valid throttling (about 30% each), ELL=10, random coeffs -> byte stream equals the software ByteEncode_10 model; byte_out stable throughout every stall.
- Assert rst for 1 cycle after 100 coefficients -> all outputs 0 immediately (asynchronously); new start then gives a correct full frame with no stale bytes.
